// File: rtl/instr_mem_pl.sv
// instr_mem_pl: instruction memory with run-time load port and registered valid/ready fetch
module instr_mem_pl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_insn,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic [ADDR_W:0]   ld_count
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic ld_in, req_in, ld_fire, req_fire;
  assign ld_ready = !rst;
  assign req_ready = !rst && !ld_valid && (!rsp_valid || rsp_ready);
  assign ld_in = {1'b0, ld_addr} < DEPTH_L;
  assign req_in = {1'b0, req_pc} < DEPTH_L;
  assign ld_fire = ld_valid && ld_ready && ld_in;
  assign req_fire = req_valid && req_ready;
  always_ff @(posedge clk)
    if (ld_fire) mem[ld_addr[IW-1:0]] <= ld_data;
  always_ff @(posedge clk)
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_insn <= NOP_WORD;
      rsp_err <= 1'b0;
      ld_count <= '0;
    end else begin
      if (req_fire) begin
        rsp_valid <= 1'b1;
        rsp_insn <= req_in ? mem[req_pc[IW-1:0]] : NOP_WORD;
        rsp_err <= !req_in;
      end else if (rsp_ready) rsp_valid <= 1'b0;
      if (ld_fire && ld_count != DEPTH_L) ld_count <= ld_count + 1'b1;
    end
endmodule

// File: tb/tb_instr_mem_pl.sv
// tb_instr_mem_pl: scoreboard bench for instr_mem_pl with DEPTH=1000
module tb_instr_mem_pl;
  logic clk = 0, rst = 1;
  logic ld_valid = 0, req_valid = 0, rsp_ready = 0;
  logic [9:0] ld_addr = 0, req_pc = 0;
  logic [15:0] ld_data = 0;
  logic ld_ready, req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_insn;
  logic [10:0] ld_count;
  int total = 0, bad = 0;
  logic [15:0] model [1000];
  logic [16:0] exp_q [$];
  logic [16:0] e;
  int exp_cnt = 0;
  instr_mem_pl #(.DATA_W(16), .ADDR_W(10), .DEPTH(1000), .NOP_WORD(16'h0000)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_insn(rsp_insn), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .ld_count(ld_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected got=%h/%b want=none", rsp_insn, rsp_err);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err, rsp_insn} !== e) begin
            bad++;
            $display("FAIL rsp_data got=%b/%h want=%b/%h", rsp_err, rsp_insn, e[16], e[15:0]);
          end
        end
      end
      if (req_valid && req_ready)
        exp_q.push_back(req_pc < 1000 ? {1'b0, model[req_pc]} : {1'b1, 16'h0000});
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  task automatic load(input logic [9:0] a, input logic [15:0] d);
    step();
    ld_valid = 1; ld_addr = a; ld_data = d;
    if (a < 1000) begin
      model[a] = d;
      if (exp_cnt < 1000) exp_cnt++;
    end
    step();
    ld_valid = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    step();
    step();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_insn", rsp_insn, 16'h0000);
    chk("rst_err", rsp_err, 0);
    chk("rst_count", ld_count, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    rst = 0;
    #1;
    chk("rel_req_ready", req_ready, 1);
    chk("rel_ld_ready", ld_ready, 1);
  endtask
  task automatic test_back_to_back();
    load(0, 16'h8080);
    load(1, 16'h8504);
    load(2, 16'h08FA);
    chk("ld_count3", ld_count, 3);
    rsp_ready = 1;
    req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      req_pc = 10'(i);
      #1;
      chk("b2b_req_ready", req_ready, 1);
      step();
      chk("b2b_rsp_valid", rsp_valid, 1);
    end
    req_valid = 0;
    step();
    chk("b2b_drain", rsp_valid, 0);
    chk("b2b_hold_insn", rsp_insn, 16'h08FA);
  endtask
  task automatic test_stall();
    rsp_ready = 0;
    req_valid = 1; req_pc = 1;
    step();
    req_pc = 2;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req_ready", req_ready, 0);
      chk("stall_insn", rsp_insn, 16'h8504);
      chk("stall_valid", rsp_valid, 1);
      step();
    end
    rsp_ready = 1;
    #1;
    chk("unstall_req_ready", req_ready, 1);
    step();
    req_valid = 0;
    chk("unstall_insn", rsp_insn, 16'h08FA);
    step();
  endtask
  task automatic test_out_of_range();
    rsp_ready = 1;
    req_valid = 1; req_pc = 10'd1010;
    step();
    req_valid = 0;
    chk("oor_err", rsp_err, 1);
    chk("oor_insn", rsp_insn, 16'h0000);
    load(10'd1010, 16'hDEAD);
    chk("oor_ld_count", ld_count, 11'(exp_cnt));
    req_valid = 1; req_pc = 10'd1010;
    step();
    req_pc = 10'd999;
    load(10'd999, 16'h1234);
    req_valid = 1; req_pc = 10'd999;
    step();
    req_valid = 0;
    chk("edge_err", rsp_err, 0);
    chk("edge_insn", rsp_insn, 16'h1234);
    step();
  endtask
  task automatic test_load_priority();
    rsp_ready = 1;
    ld_valid = 1; ld_addr = 5; ld_data = 16'hABCD; model[5] = 16'hABCD; exp_cnt++;
    req_valid = 1; req_pc = 5;
    #1;
    chk("lp_req_ready", req_ready, 0);
    step();
    ld_valid = 0;
    #1;
    chk("lp_req_ready2", req_ready, 1);
    step();
    req_valid = 0;
    chk("lp_insn", rsp_insn, 16'hABCD);
    chk("lp_count", ld_count, 11'(exp_cnt));
    step();
  endtask
  task automatic test_pending_load();
    rsp_ready = 0;
    req_valid = 1; req_pc = 5;
    step();
    req_valid = 0;
    ld_valid = 1; ld_addr = 5; ld_data = 16'h5555; model[5] = 16'h5555; exp_cnt++;
    step();
    ld_valid = 0;
    chk("pend_insn", rsp_insn, 16'hABCD);
    rsp_ready = 1;
    step();
    req_valid = 1; req_pc = 5;
    step();
    req_valid = 0;
    chk("pend_new", rsp_insn, 16'h5555);
    step();
  endtask
  task automatic test_mid_reset();
    rsp_ready = 0;
    req_valid = 1; req_pc = 0;
    step();
    req_valid = 0;
    chk("mr_valid_pre", rsp_valid, 1);
    rst = 1; ld_valid = 1; ld_addr = 1; ld_data = 16'hFFFF;
    #1;
    chk("mr_ld_ready", ld_ready, 0);
    chk("mr_req_ready", req_ready, 0);
    step();
    ld_valid = 0;
    chk("mr_valid", rsp_valid, 0);
    chk("mr_insn", rsp_insn, 16'h0000);
    chk("mr_count", ld_count, 0);
    exp_q.delete();
    exp_cnt = 0;
    rst = 0;
    rsp_ready = 1;
    req_valid = 1; req_pc = 1;
    step();
    req_pc = 2;
    step();
    req_valid = 0;
    chk("mr_keep", rsp_insn, 16'h08FA);
    step();
  endtask
  task automatic test_saturate();
    ld_valid = 1;
    for (int i = 0; i < 1005; i++) begin
      ld_addr = 10'(i % 1000); ld_data = 16'(i);
      model[i % 1000] = 16'(i);
      if (exp_cnt < 1000) exp_cnt++;
      step();
    end
    ld_valid = 0;
    chk("sat_count", ld_count, 11'd1000);
    rsp_ready = 1;
    req_valid = 1; req_pc = 10'd3;
    step();
    req_valid = 0;
    chk("sat_insn", rsp_insn, 16'd1003);
    step();
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_out_of_range();
    test_load_priority();
    test_pending_load();
    test_mid_reset();
    test_saturate();
    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
